// File: rtl/iob_eth_rx_buf_wr.sv
// Ethernet receive buffer writer: packs received bytes into a 32-bit word RAM
// and holds one complete good frame. Optional IOB_ETH_RX_DROP_CNT_EN adds drop_cnt.
module iob_eth_rx_buf_wr #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              rx_last,
    input  logic              rx_err,
    input  logic              frame_ack,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              frame_ready,
    output logic [ADDR_W+2:0] frame_len,
    output logic              drop_pulse
`ifdef IOB_ETH_RX_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int BCNT_W = ADDR_W + 3;
    // Index of the last byte slot in the buffer; a non-last byte here overflows.
    localparam logic [BCNT_W-1:0] BCNT_MAX = {1'b0, {(ADDR_W+2){1'b1}}};

    typedef enum logic [1:0] {IDLE, FILL, HOLD, DROP} state_t;

    state_t            state, state_nxt;
    logic [BCNT_W-1:0] bcnt;
    logic              wr, drop, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FILL: begin
                if (rx_valid) begin
                    if (rx_err)              state_nxt = rx_last ? IDLE : DROP;
                    else if (rx_last)        state_nxt = HOLD;
                    else if (bcnt == BCNT_MAX) state_nxt = DROP;
                    else                     state_nxt = FILL;
                end
            end
            HOLD: begin
                if (rx_valid && !rx_last) state_nxt = DROP;
                else if (frame_ack)       state_nxt = IDLE;
            end
            DROP: begin
                if (rx_valid && rx_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr   = 1'b0;
        drop = 1'b0;
        done = 1'b0;
        case (state)
            IDLE, FILL: begin
                wr   = rx_valid && !rx_err;
                done = rx_valid && !rx_err && rx_last;
                drop = rx_valid && rx_err && rx_last;
            end
            HOLD:    drop = rx_valid && rx_last;
            DROP:    drop = rx_valid && rx_last;
            default: ;
        endcase
    end

    // bcnt only advances while the frame keeps filling; any exit clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 bcnt <= '0;
        else if (state_nxt != FILL) bcnt <= '0;
        else if (wr)                bcnt <= bcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en      <= 1'b0;
            ram_we      <= 4'b0;
            ram_addr    <= '0;
            ram_din     <= 32'b0;
            frame_ready <= 1'b0;
            frame_len   <= '0;
            drop_pulse  <= 1'b0;
        end else begin
            ram_en      <= wr;
            ram_we      <= wr ? (4'b0001 << bcnt[1:0]) : 4'b0;
            if (wr) begin
                ram_addr <= bcnt[ADDR_W+1:2];
                ram_din  <= {4{rx_byte}};
            end
            frame_ready <= (state_nxt == HOLD);
            if (done) frame_len <= bcnt + 1'b1;
            drop_pulse  <= drop;
        end
    end

`ifdef IOB_ETH_RX_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          drop_cnt <= 16'h0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'h1;
    end
`endif

endmodule

// File: doc/iob_eth_rx_buf_wr.md
IOB_ETH_RX_BUF_WR -- requirements
Module: iob_eth_rx_buf_wr

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning buffer word-address width (2**ADDR_W 32-bit words).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_valid  input  1  received byte present this cycle.
REQ-005 SHALL have port rx_byte  input  8  received byte.
REQ-006 SHALL have port rx_last  input  1  qualifies rx_valid; final byte of frame.
REQ-007 SHALL have port rx_err  input  1  qualifies rx_valid; frame is corrupt.
REQ-008 SHALL have port frame_ack  input  1  single-cycle host pulse: frame consumed, buffer released.
REQ-009 SHALL have port ram_en  output  1  buffer write-port enable.
REQ-010 SHALL have port ram_we  output  4  byte-lane write enables.
REQ-011 SHALL have port ram_addr  output  ADDR_W  buffer word address.
REQ-012 SHALL have port ram_din  output  32  buffer write data.
REQ-013 SHALL have port frame_ready  output  1  complete good frame held in buffer.
REQ-014 SHALL have port frame_len  output  ADDR_W+3  byte count of held frame.
REQ-015 SHALL have port drop_pulse  output  1  one-cycle pulse per discarded frame.

Function
REQ-016 SHALL implement states IDLE, FILL, HOLD, DROP; internal byte counter bcnt of ADDR_W+3 bits.
REQ-017 Accepted byte (rx_valid in IDLE/FILL) SHALL produce, registered one cycle later: ram_en=1, ram_addr=bcnt[ADDR_W+1:2], ram_we=one-hot of bcnt[1:0] (lane 0 = bits 7:0), ram_din={4{rx_byte}}; bcnt then increments.
REQ-018 Cycles with no accepted byte SHALL drive ram_en=0, ram_we=0; ram_addr/ram_din hold.
REQ-019 IDLE: bcnt=0; rx_valid&!rx_err&!rx_last -> FILL; rx_valid&rx_last&!rx_err -> HOLD with frame_len=1.
REQ-020 FILL: rx_valid&rx_last&!rx_err -> HOLD, frame_len=bcnt+1, frame_ready=1 from next cycle.
REQ-021 rx_valid&rx_err in IDLE/FILL SHALL suppress that byte's write; rx_last set -> IDLE with drop_pulse, else -> DROP.
REQ-022 Overflow: rx_valid&!rx_last in FILL with bcnt=4*2**ADDR_W-1 SHALL write that byte then -> DROP; rx_last on that byte is a legal full-buffer frame (frame_len=4*2**ADDR_W).
REQ-023 DROP: no RAM writes; rx_valid&rx_last -> IDLE with drop_pulse next cycle.
REQ-024 HOLD: frame_ready=1, frame_len stable, no RAM writes; frame_ack -> IDLE, frame_ready=0 next cycle.
REQ-025 HOLD: rx_valid&!rx_last (frame_ack irrelevant) -> DROP; rx_valid&rx_last -> drop_pulse, stays HOLD unless frame_ack same cycle (then IDLE).
REQ-026 frame_ack outside HOLD SHALL be ignored.
REQ-027 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, bcnt=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, frame_ready=0, frame_len=0, drop_pulse=0.
REQ-029 Reset mid-frame SHALL abandon the frame without drop_pulse; partial buffer content is don't-care.

Configuration
REQ-030 Macro IOB_ETH_RX_DROP_CNT_EN defined SHALL add output drop_cnt (16 bits), reset 0, incremented on each drop_pulse, saturating at 16'hFFFF.
REQ-031 Macro undefined SHALL omit drop_cnt port and counter; all other behaviour identical.

Verification
REQ-032 Frame bytes 11,22,33,44,55 (last on 55) -> writes addr0 we 1,2,4,8 then addr1 we 1; frame_ready=1, frame_len=5.
REQ-033 frame_ready held, frame_ack pulse -> frame_ready=0 next cycle; next frame written from addr0 lane0.
REQ-034 ADDR_W=2, 17-byte frame -> 16 writes, no write for byte 17, drop_pulse once at last, frame_ready stays 0.
REQ-035 Byte 3 of frame with rx_err=1 -> no further writes, drop_pulse after rx_last, state IDLE.
REQ-036 Frame arriving during HOLD -> no writes, drop_pulse once, first frame_len unchanged; with macro, drop_cnt=1.
REQ-037 rst_n low during FILL after 6 bytes -> outputs at reset values asynchronously, no drop_pulse; next frame starts at addr0.
